// File: rtl/pulse_program_loader.sv
// pulse_program_loader: parses header+payload command packets into inst list, amp memory and default amp writes
module pulse_program_loader #(
    parameter int CMD_WIDTH             = 32,
    parameter int GLB_COUNTER_WIDTH     = 24,
    parameter int DIRECTION_WIDTH       = 2,
    parameter int AMP_WIDTH             = 12,
    parameter int LENGTH_WIDTH          = 7,
    parameter int INST_LIST_ADDR_WIDTH  = 5,
    parameter int INST_LIST_DATA_WIDTH  = GLB_COUNTER_WIDTH + DIRECTION_WIDTH,
    parameter int AMP_MEMORY_ADDR_WIDTH = 9,
    parameter int AMP_MEMORY_DATA_WIDTH = AMP_WIDTH + LENGTH_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cmd_valid_i,
    input  logic [CMD_WIDTH-1:0]             cmd_data_i,
    output logic                             cmd_ready_o,
    input  logic                             err_clr_i,
    output logic                             inst_list_wr_en_o,
    output logic [INST_LIST_ADDR_WIDTH-1:0]  inst_list_wr_addr_o,
    output logic [INST_LIST_DATA_WIDTH-1:0]  inst_list_wr_data_o,
    output logic                             amp_memory_wr_en_o,
    output logic [AMP_MEMORY_ADDR_WIDTH-1:0] amp_memory_wr_addr_o,
    output logic [AMP_MEMORY_DATA_WIDTH-1:0] amp_memory_wr_data_o,
    output logic                             default_amp_wr_en_o,
    output logic [AMP_WIDTH-1:0]             default_amp_wr_data_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    localparam logic [1:0] OP_INST = 2'd0;
    localparam logic [1:0] OP_AMP  = 2'd1;
    localparam logic [1:0] OP_DEF  = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    state_t                           state_q;
    logic [1:0]                       op_q;
    logic [AMP_MEMORY_ADDR_WIDTH-1:0] addr_q;
    logic [8:0]                       cnt_q;
    logic                             cmd_ready_q;
    logic                             error_q;
    logic                             error_d;
    logic                             acc;
    logic                             hdr_bad;
    logic [1:0]                       hdr_op;
    logic [AMP_MEMORY_ADDR_WIDTH-1:0] hdr_addr;
    logic [8:0]                       hdr_cnt;
    logic                             unused_bits;

    assign hdr_op      = cmd_data_i[31:30];
    assign hdr_addr    = cmd_data_i[29:21];
    assign hdr_cnt     = cmd_data_i[20:12];
    assign unused_bits = ^cmd_data_i[CMD_WIDTH-1:INST_LIST_DATA_WIDTH];
    assign cmd_ready_o = cmd_ready_q;
    assign error_o     = error_q;
    assign busy_o      = state_q != IDLE;

    // Handshake, header validity and sticky-error next state (a new error beats a clear)
    always_comb begin
        acc     = cmd_valid_i & cmd_ready_q;
        hdr_bad = (hdr_op == OP_INST && hdr_addr[AMP_MEMORY_ADDR_WIDTH-1:INST_LIST_ADDR_WIDTH] != '0) ||
                  (hdr_op == OP_DEF && hdr_addr != '0);
        error_d = (state_q == IDLE && acc && hdr_bad) ? 1'b1 : (err_clr_i ? 1'b0 : error_q);
    end

    // Packet FSM with registered write strobes, addresses, data and done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q               <= IDLE;
            op_q                  <= OP_INST;
            addr_q                <= '0;
            cnt_q                 <= '0;
            cmd_ready_q           <= 1'b0;
            error_q               <= 1'b0;
            done_o                <= 1'b0;
            inst_list_wr_en_o     <= 1'b0;
            inst_list_wr_addr_o   <= '0;
            inst_list_wr_data_o   <= '0;
            amp_memory_wr_en_o    <= 1'b0;
            amp_memory_wr_addr_o  <= '0;
            amp_memory_wr_data_o  <= '0;
            default_amp_wr_en_o   <= 1'b0;
            default_amp_wr_data_o <= '0;
        end else begin
            cmd_ready_q         <= 1'b1;
            error_q             <= error_d;
            done_o              <= 1'b0;
            inst_list_wr_en_o   <= 1'b0;
            amp_memory_wr_en_o  <= 1'b0;
            default_amp_wr_en_o <= 1'b0;
            case (state_q)
                IDLE: if (acc) begin
                    op_q   <= hdr_op;
                    addr_q <= hdr_addr;
                    cnt_q  <= hdr_cnt;
                    if (hdr_op == OP_NOP) done_o <= 1'b1;
                    else state_q <= hdr_bad ? DRAIN : LOAD;
                end
                LOAD: if (acc) begin
                    inst_list_wr_en_o   <= op_q == OP_INST;
                    amp_memory_wr_en_o  <= op_q == OP_AMP;
                    default_amp_wr_en_o <= op_q == OP_DEF;
                    if (op_q == OP_INST) begin
                        inst_list_wr_addr_o <= addr_q[INST_LIST_ADDR_WIDTH-1:0];
                        inst_list_wr_data_o <= cmd_data_i[INST_LIST_DATA_WIDTH-1:0];
                    end
                    if (op_q == OP_AMP) begin
                        amp_memory_wr_addr_o <= addr_q;
                        amp_memory_wr_data_o <= cmd_data_i[AMP_MEMORY_DATA_WIDTH-1:0];
                    end
                    if (op_q == OP_DEF) default_amp_wr_data_o <= cmd_data_i[AMP_WIDTH-1:0];
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        done_o  <= 1'b1;
                    end
                end
                DRAIN: if (acc) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_program_loader.sv
// tb_pulse_program_loader: randomized scoreboard bench for pulse_program_loader
module tb_pulse_program_loader;
    typedef struct packed {
        logic [2:0]  en;
        logic        dn;
        logic [8:0]  addr;
        logic [25:0] data;
    } ev_t;

    logic        clk = 0, rst_ni = 0, cmd_valid = 0, err_clr = 0;
    logic [31:0] cmd_data = 0;
    logic        cmd_ready, inst_we, amp_we, def_we, busy, done, error;
    logic [4:0]  inst_addr;
    logic [25:0] inst_data;
    logic [8:0]  amp_addr;
    logic [18:0] amp_data;
    logic [11:0] def_data;

    int          checks = 0, errors = 0;
    ev_t         exp_q[$];
    logic [31:0] pl[$];
    bit          model_err = 0;
    ev_t         mon_got, mon_exp;

    pulse_program_loader dut (
        .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid), .cmd_data_i(cmd_data),
        .cmd_ready_o(cmd_ready), .err_clr_i(err_clr),
        .inst_list_wr_en_o(inst_we), .inst_list_wr_addr_o(inst_addr), .inst_list_wr_data_o(inst_data),
        .amp_memory_wr_en_o(amp_we), .amp_memory_wr_addr_o(amp_addr), .amp_memory_wr_data_o(amp_data),
        .default_amp_wr_en_o(def_we), .default_amp_wr_data_o(def_data),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe or done must match the oldest expected event
    always @(negedge clk) begin
        if (rst_ni && {inst_we, amp_we, def_we, done} != 4'b0) begin
            mon_got.en   = {inst_we, amp_we, def_we};
            mon_got.dn   = done;
            mon_got.addr = inst_we ? 9'(inst_addr) : (amp_we ? amp_addr : 9'd0);
            mon_got.data = inst_we ? inst_data : (amp_we ? 26'(amp_data) : (def_we ? 26'(def_data) : 26'd0));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL write_event: got en=%b dn=%b addr=%0d data=%h expected en=%b dn=%b addr=%0d data=%h",
                             mon_got.en, mon_got.dn, mon_got.addr, mon_got.data,
                             mon_exp.en, mon_exp.dn, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            cmd_valid = 0;
            cmd_data  = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [31:0] w);
        cmd_valid = 1;
        cmd_data  = w;
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic clr_err();
        err_clr = 1;
        idle(1);
        err_clr = 0;
        model_err = 0;
        chk("error_cleared", error, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_strobes", {inst_we, amp_we, def_we, done, busy, error}, 0);
        chk("rst_addr_data", {inst_addr, inst_data, amp_addr, amp_data, def_data}, 0);
    endtask

    // Reference: a packet is a header plus count+1 words; writes go to start+i modulo the target depth
    task automatic send_pkt(logic [1:0] op, logic [8:0] sa, logic [8:0] cnt, int gap, bit clr);
        bit          bad;
        logic [31:0] w;
        ev_t         e;
        bad = (op == 0 && sa >= 32) || (op == 2 && sa != 0);
        if (op == 3) exp_q.push_back('{en: 3'b000, dn: 1'b1, addr: 9'd0, data: 26'd0});
        err_clr = clr;
        send({op, sa, cnt, 12'($urandom)});
        err_clr = 0;
        model_err = bad ? 1'b1 : (clr ? 1'b0 : model_err);
        chk("busy_hdr", busy, op != 3);
        chk("error_hdr", error, model_err);
        if (op == 3) return;
        for (int i = 0; i <= cnt; i++) begin
            w = pl.size() != 0 ? pl.pop_front() : $urandom;
            if (!bad) begin
                e.en   = op == 0 ? 3'b100 : (op == 1 ? 3'b010 : 3'b001);
                e.dn   = i == cnt;
                e.addr = op == 0 ? 9'((sa + i) % 32) : (op == 1 ? 9'((sa + i) % 512) : 9'd0);
                e.data = op == 0 ? w[25:0] : (op == 1 ? 26'(w[18:0]) : 26'(w[11:0]));
                exp_q.push_back(e);
            end
            send(w);
            if (i < cnt) idle(gap >= 0 ? gap : ($urandom_range(99) < 30 ? $urandom_range(3, 1) : 0));
        end
        chk("busy_end", busy, 0);
        chk("error_end", error, model_err);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_ni = 1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        pl = '{32'h0000065, 32'h00000C9, 32'h000012E};
        send_pkt(2'd0, 9'd3, 9'd2, 0, 0);
        send_pkt(2'd1, 9'd510, 9'd3, 0, 0);
        send_pkt(2'd0, 9'h20, 9'd1, 0, 0);
        chk("error_set", error, 1);
        clr_err();
        pl = '{32'h7FF};
        send_pkt(2'd2, 9'd0, 9'd0, 0, 0);
        send_pkt(2'd3, 9'd0, 9'd0, 0, 0);
        chk("nop_busy", busy, 0);
        send_pkt(2'd1, 9'd40, 9'd3, 2, 0);
        send_pkt(2'd2, 9'd5, 9'd1, 0, 1);
        chk("set_beats_clear", error, 1);
        clr_err();

        repeat (40) begin
            logic [1:0] op;
            logic [8:0] sa;
            op = 2'($urandom_range(3));
            sa = $urandom_range(99) < 60 ? 9'($urandom_range(op == 2 ? 0 : 31)) : 9'($urandom);
            send_pkt(op, sa, 9'($urandom_range(12)), -1, $urandom_range(9) == 0);
            if ($urandom_range(5) == 0) clr_err();
        end

        send({2'd1, 9'd100, 9'd3, 12'd0});
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = $urandom;
            exp_q.push_back('{en: 3'b010, dn: 1'b0, addr: 9'(100 + i), data: 26'(w[18:0])});
            send(w);
        end
        @(negedge clk);
        #2;
        rst_ni = 0;
        #1;
        check_reset_outputs();
        model_err = 0;
        @(negedge clk);
        rst_ni = 1;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", cmd_ready, 1);
        send_pkt(2'd3, 9'd0, 9'd0, 0, 0);
        send_pkt(2'd0, 9'd30, 9'd4, -1, 0);

        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_program_loader.md
PULSE_PROGRAM_LOADER -- requirements
Module: pulse_program_loader

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- CMD_WIDTH, 32, command word width
- GLB_COUNTER_WIDTH, 24, timestamp field width
- DIRECTION_WIDTH, 2, direction field width
- AMP_WIDTH, 12, amplitude width
- LENGTH_WIDTH, 7, segment length width
- INST_LIST_ADDR_WIDTH, 5, inst list address width
- INST_LIST_DATA_WIDTH, 26, equal to GLB_COUNTER_WIDTH+DIRECTION_WIDTH
- AMP_MEMORY_ADDR_WIDTH, 9, amp memory address width
- AMP_MEMORY_DATA_WIDTH, 19, equal to AMP_WIDTH+LENGTH_WIDTH
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; one clock; reset is asynchronous and active-low
- rst, in, 1, asynchronous active-low reset
- cmd_valid, in, 1, command word offered
- cmd_data, in, CMD_WIDTH, command word
- cmd_ready, out, 1, word accepted when cmd_valid&cmd_ready
- err_clr, in, 1, clears the sticky error
- inst_list_wr_en, out, 1, inst list write strobe
- inst_list_wr_addr, out, INST_LIST_ADDR_WIDTH, inst list write address
- inst_list_wr_data, out, INST_LIST_DATA_WIDTH, {timestamp, direction}
- amp_memory_wr_en, out, 1, amp memory write strobe
- amp_memory_wr_addr, out, AMP_MEMORY_ADDR_WIDTH, amp memory write address
- amp_memory_wr_data, out, AMP_MEMORY_DATA_WIDTH, {amp, length}
- default_amp_wr_en, out, 1, default amplitude write strobe
- default_amp_wr_data, out, AMP_WIDTH, default amplitude
- busy, out, 1, packet in progress
- done, out, 1, one-cycle pulse on packet completion
- error, out, 1, sticky error flag

Function
REQ-003 Each packet SHALL consist of one header word followed by N=count+1 payload words.
REQ-004 Header fields SHALL be: opcode [31:30] (0=INST, 1=AMP, 2=DEFAULT, 3=NOP), start_addr [29:21], count [20:12]. Bits [11:0] SHALL be ignored.
REQ-005 The FSM SHALL have exactly three states: IDLE, LOAD, DRAIN.
REQ-006 IDLE transitions:
- Header accepted with NOP: stay in IDLE, no payload expected, done pulses.
- Valid header (INST, AMP, DEFAULT): go to LOAD.
- Invalid header: go to DRAIN and set error.
REQ-007 A header SHALL be invalid when opcode=INST and start_addr[8:5]!=0, or opcode=DEFAULT and start_addr!=0.
REQ-008 cmd_ready SHALL be 1 in all states except during reset.
REQ-009 Each accepted payload word in LOAD SHALL produce exactly one write strobe on the selected port, registered one cycle after the handshake, carrying the current address and the low data bits of the word:
- INST: [25:0]
- AMP: [18:0]
- DEFAULT: [11:0], no address
REQ-010 The address SHALL start at start_addr and increment by 1 after each payload word, wrapping modulo 2^INST_LIST_ADDR_WIDTH for INST and 2^AMP_MEMORY_ADDR_WIDTH for AMP. Unused upper payload bits SHALL be ignored.
REQ-011 The remaining-word counter SHALL be 9 bits and load count. The last word is accepted when the counter is 0; the FSM then returns to IDLE and done pulses in the same cycle as the last write strobe.
REQ-012 DRAIN SHALL accept and discard count+1 payload words with no write strobes, then return to IDLE. done SHALL NOT pulse for a drained packet.
REQ-013 At most one write-enable output SHALL be high in any cycle. All wr_en, done, and the registered addr/data outputs SHALL be driven from flops.
REQ-014 busy SHALL be 1 in LOAD and DRAIN and 0 in IDLE.
REQ-015 error SHALL stay set until err_clr=1 is sampled. If a set event and err_clr occur in the same cycle, the set SHALL win.
REQ-016 Cycles with cmd_valid=0 SHALL stall the packet with no strobes and no state or counter change.

Reset
REQ-017 While rst=0, asynchronously:
- FSM=IDLE
- all outputs 0 (cmd_ready=0, all wr_en/addr/data=0, busy=0, done=0, error=0)
- internal address and counter 0
REQ-018 A reset mid-packet SHALL abandon the packet. Words arriving after reset release SHALL be parsed as a new header.
REQ-019 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-020 Directed scenarios:
- INST header start=3, count=2, payloads 0x0000065, 0x00000C9, 0x000012E -> inst_list_wr_en on 3 cycles at addr 3,4,5 with those data; done with the last strobe; busy=0 after.
- AMP header start=510, count=3 -> strobes at addr 510,511,0,1 (wrap).
- INST header start_addr=0x20 plus 2 payloads -> error=1, no strobes, no done, FSM back in IDLE after 2 words; err_clr -> error=0.
- DEFAULT header count=0, payload 0x7FF -> one default_amp_wr_en with data 0x7FF; then NOP header -> done pulse, busy stays 0.
- AMP packet with cmd_valid toggling 1,0,0,1 -> strobes only on accepted words, addresses contiguous.
- rst asserted after the 2nd of 4 AMP payloads -> outputs immediately 0; next word after release decoded as header.
